// File: rtl/object_draw_engine_if.sv
// Request/position inputs and pixel outputs exchanged between the frame draw
// controller side (master) and the object draw engine (slave).
interface object_draw_engine_if;
  logic [3:0] objectToDraw;
  logic       inEraseState;
  logic [7:0] playerX;
  logic [6:0] playerY;
  logic [7:0] enemyX [4];
  logic [6:0] enemyY [4];
  logic [3:0] enemyAlive;
  logic [7:0] bulletX;
  logic [6:0] bulletY;
  logic       bulletActive;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       pixelValid;
  logic       doneDrawing;
  logic       doneErasing;

  modport master (
    output objectToDraw, inEraseState, playerX, playerY, enemyX, enemyY,
           enemyAlive, bulletX, bulletY, bulletActive,
    input  x, y, colour, pixelValid, doneDrawing, doneErasing
  );

  modport slave (
    input  objectToDraw, inEraseState, playerX, playerY, enemyX, enemyY,
           enemyAlive, bulletX, bulletY, bulletActive,
    output x, y, colour, pixelValid, doneDrawing, doneErasing
  );
endinterface

// File: rtl/object_draw_engine.sv
// Object/erase pixel scanner: one pixel per clock, registered outputs, done pulses.
// Optional macro ERASE_STARFIELD_EN paints a dot every 8th pixel/row during erase.
module object_draw_engine #(
  parameter int         SCREEN_W = 160,
  parameter int         SCREEN_H = 120,
  parameter int         PLAYER_W = 8,
  parameter int         PLAYER_H = 8,
  parameter int         ENEMY_W  = 8,
  parameter int         ENEMY_H  = 8,
  parameter int         BULLET_W = 2,
  parameter int         BULLET_H = 4,
  parameter logic [2:0] C_PLAYER = 3'b010,
  parameter logic [2:0] C_ENEMY  = 3'b100,
  parameter logic [2:0] C_BULLET = 3'b111
) (
  input logic                 clk,
  input logic                 resetn,
  object_draw_engine_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ERASE, DRAW, DONE, HOLD} state_t;

  localparam logic [8:0] SCR_W9 = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H8 = 8'(SCREEN_H);
`ifdef ERASE_STARFIELD_EN
  localparam logic [2:0] ERASE_ORIGIN_C = 3'b111;
`else
  localparam logic [2:0] ERASE_ORIGIN_C = 3'b000;
`endif

  state_t     state_q;
  logic [7:0] org_x_q, w_q, dx_q, x_q;
  logic [6:0] org_y_q, h_q, dy_q, y_q;
  logic [2:0] col_q, colour_q;
  logic       valid_q, done_draw_q, done_erase_q;

  logic [7:0] sel_x, sel_w;
  logic [6:0] sel_y, sel_h;
  logic [2:0] sel_col;
  logic       sel_req, sel_live, sel_on_screen;
  logic [1:0] enemy_idx;

  assign enemy_idx = bus.objectToDraw[1:0] - 2'd2;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_w    = '0;
    sel_h    = '0;
    sel_col  = '0;
    sel_req  = 1'b0;
    sel_live = 1'b0;
    case (bus.objectToDraw)
      4'd1: begin
        sel_x = bus.playerX; sel_y = bus.playerY;
        sel_w = 8'(PLAYER_W); sel_h = 7'(PLAYER_H);
        sel_col = C_PLAYER; sel_req = 1'b1; sel_live = 1'b1;
      end
      4'd2, 4'd3, 4'd4, 4'd5: begin
        sel_x = bus.enemyX[enemy_idx]; sel_y = bus.enemyY[enemy_idx];
        sel_w = 8'(ENEMY_W); sel_h = 7'(ENEMY_H);
        sel_col = C_ENEMY; sel_req = 1'b1; sel_live = bus.enemyAlive[enemy_idx];
      end
      4'd6: begin
        sel_x = bus.bulletX; sel_y = bus.bulletY;
        sel_w = 8'(BULLET_W); sel_h = 7'(BULLET_H);
        sel_col = C_BULLET; sel_req = 1'b1; sel_live = bus.bulletActive;
      end
      default: ;
    endcase
  end

  assign sel_on_screen = ({1'b0, sel_x} < SCR_W9) && ({1'b0, sel_y} < SCR_H8);

  // Next pixel of the running scan; the 9/8-bit sums let clipping see overflow.
  logic       last_col, last_row, px_on_screen;
  logic [7:0] nx_dx;
  logic [6:0] nx_dy;
  logic [8:0] px;
  logic [7:0] py;
  logic [2:0] erase_c;

  assign last_col     = (dx_q == w_q - 8'd1);
  assign last_row     = (dy_q == h_q - 7'd1);
  assign nx_dx        = last_col ? 8'd0 : dx_q + 8'd1;
  assign nx_dy        = last_col ? dy_q + 7'd1 : dy_q;
  assign px           = {1'b0, org_x_q} + {1'b0, nx_dx};
  assign py           = {1'b0, org_y_q} + {1'b0, nx_dy};
  assign px_on_screen = (px < SCR_W9) && (py < SCR_H8);
`ifdef ERASE_STARFIELD_EN
  assign erase_c = (px[2:0] == 3'd0 && py[2:0] == 3'd0) ? 3'b111 : 3'b000;
`else
  assign erase_c = 3'b000;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      org_x_q      <= '0;
      org_y_q      <= '0;
      w_q          <= '0;
      h_q          <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      col_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      valid_q      <= 1'b0;
      done_draw_q  <= 1'b0;
      done_erase_q <= 1'b0;
    end else begin
      done_draw_q  <= 1'b0;
      done_erase_q <= 1'b0;
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (bus.inEraseState) begin
            state_q  <= ERASE;
            org_x_q  <= '0;
            org_y_q  <= '0;
            w_q      <= 8'(SCREEN_W);
            h_q      <= 7'(SCREEN_H);
            dx_q     <= '0;
            dy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= ERASE_ORIGIN_C;
            valid_q  <= 1'b1;
          end else if (sel_req && sel_live) begin
            state_q  <= DRAW;
            org_x_q  <= sel_x;
            org_y_q  <= sel_y;
            w_q      <= sel_w;
            h_q      <= sel_h;
            col_q    <= sel_col;
            dx_q     <= '0;
            dy_q     <= '0;
            x_q      <= sel_x;
            y_q      <= sel_y;
            colour_q <= sel_col;
            valid_q  <= sel_on_screen;
          end else if (sel_req) begin
            state_q     <= DONE;
            done_draw_q <= 1'b1;
          end
        end
        ERASE, DRAW: begin
          if (last_col && last_row) begin
            state_q      <= DONE;
            valid_q      <= 1'b0;
            done_erase_q <= (state_q == ERASE);
            done_draw_q  <= (state_q == DRAW);
          end else begin
            dx_q     <= nx_dx;
            dy_q     <= nx_dy;
            x_q      <= px[7:0];
            y_q      <= py[6:0];
            valid_q  <= px_on_screen;
            colour_q <= (state_q == ERASE) ? erase_c : col_q;
          end
        end
        DONE: state_q <= HOLD;
        HOLD: begin
          // Stay parked until the controller has released both requests.
          if (bus.objectToDraw == 4'd0 && !bus.inEraseState) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.colour      = colour_q;
  assign bus.pixelValid  = valid_q;
  assign bus.doneDrawing = done_draw_q;
  assign bus.doneErasing = done_erase_q;

endmodule

// File: tb/tb_object_draw_engine.sv
// Self-checking bench for object_draw_engine: per-cycle comparison against a
// queue of expected outputs built from the pixel-scan rules; ERASE_STARFIELD_EN aware.
module tb_object_draw_engine;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  object_draw_engine_if bus ();

  object_draw_engine dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       v;
    logic       dd;
    logic       de;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_x;
  logic [6:0] last_y;
  logic [2:0] last_c;
  int         n_checks;
  int         n_fail;
  bit         chk_en;
  int         obs_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] dut_out();
    return {bus.x, bus.y, bus.colour, bus.pixelValid, bus.doneDrawing, bus.doneErasing};
  endfunction

  // Per-cycle compare: pending expectations first, else idle with held x/y/colour.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = {last_x, last_y, last_c, 3'b000};
      check("pixel", 32'(dut_out()), 32'(e));
      if (bus.pixelValid) obs_valid++;
    end
  end

  task automatic push(input int px, input int py, input logic [2:0] c,
                      input bit v, input bit dd, input bit de);
    exp_t e;
    e.x = 8'(px); e.y = 7'(py); e.c = c; e.v = v; e.dd = dd; e.de = de;
    exp_q.push_back(e);
    last_x = e.x; last_y = e.y; last_c = e.c;
  endtask

  function automatic logic [2:0] erase_colour(input int ex, input int ey);
`ifdef ERASE_STARFIELD_EN
    return (ex % 8 == 0 && ey % 8 == 0) ? 3'b111 : 3'b000;
`else
    return 3'b000;
`endif
  endfunction

  // Model: what the engine must emit for the request currently on the bus.
  task automatic model_request();
    int ox, oy, w, h;
    logic [2:0] c;
    bit live, req;
    if (bus.inEraseState) begin
      for (int yy = 0; yy < 120; yy++)
        for (int xx = 0; xx < 160; xx++)
          push(xx, yy, erase_colour(xx, yy), 1'b1, 1'b0, 1'b0);
      push(last_x, last_y, last_c, 1'b0, 1'b0, 1'b1);
      return;
    end
    req = 1'b1; live = 1'b1; ox = 0; oy = 0; w = 0; h = 0; c = 3'b000;
    if (bus.objectToDraw == 4'd1) begin
      ox = bus.playerX; oy = bus.playerY; w = 8; h = 8; c = 3'b010;
    end else if (bus.objectToDraw >= 4'd2 && bus.objectToDraw <= 4'd5) begin
      int k;
      k = int'(bus.objectToDraw) - 2;
      ox = bus.enemyX[k]; oy = bus.enemyY[k]; w = 8; h = 8; c = 3'b100;
      live = bus.enemyAlive[k];
    end else if (bus.objectToDraw == 4'd6) begin
      ox = bus.bulletX; oy = bus.bulletY; w = 2; h = 4; c = 3'b111;
      live = bus.bulletActive;
    end else begin
      req = 1'b0;
    end
    if (!req) return;
    if (live)
      for (int dy = 0; dy < h; dy++)
        for (int dx = 0; dx < w; dx++)
          push(ox + dx, oy + dy, c, (ox + dx < 160) && (oy + dy < 120), 1'b0, 1'b0);
    push(last_x, last_y, last_c, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic scramble_objects();
    bus.playerX = 8'($urandom); bus.playerY = 7'($urandom);
    for (int i = 0; i < 4; i++) begin
      bus.enemyX[i] = 8'($urandom); bus.enemyY[i] = 7'($urandom);
    end
    bus.enemyAlive = 4'($urandom);
    bus.bulletX = 8'($urandom); bus.bulletY = 7'($urandom);
    bus.bulletActive = 1'($urandom);
  endtask

  task automatic start_req(input logic [3:0] code, input bit erase);
    @(negedge clk); #1;
    bus.objectToDraw = code;
    bus.inEraseState = erase;
    model_request();
  endtask

  // Run until the expected stream drains (bounded), holding or dropping the request.
  task automatic finish_req(input bit drop_mid);
    int budget, cyc;
    budget = exp_q.size() + 5;
    cyc = 0;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk); #1;
      scramble_objects();
      cyc++; budget--;
      if (drop_mid && cyc == 3) begin
        bus.objectToDraw = 4'd0; bus.inEraseState = 1'b0;
      end
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    bus.objectToDraw = 4'd0; bus.inEraseState = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; chk_en = 1'b0; obs_valid = 0;
    last_x = '0; last_y = '0; last_c = '0;
    resetn = 1'b0;
    bus.objectToDraw = 4'd0; bus.inEraseState = 1'b0;
    bus.playerX = '0; bus.playerY = '0;
    for (int i = 0; i < 4; i++) begin bus.enemyX[i] = '0; bus.enemyY[i] = '0; end
    bus.enemyAlive = '0; bus.bulletX = '0; bus.bulletY = '0; bus.bulletActive = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", 32'(dut_out()), 32'd0);
    #1 resetn = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Player at (10,100).
    bus.playerX = 8'd10; bus.playerY = 7'd100;
    start_req(4'd1, 1'b0);
    check("player_len", 32'(exp_q.size()), 32'd65);
    check("player_first", 32'(exp_q[0]), 32'({8'd10, 7'd100, 3'b010, 3'b100}));
    check("player_last", 32'({exp_q[63].x, exp_q[63].y}), 32'({8'd17, 7'd107}));
    check("player_done", 32'(exp_q[64].dd), 32'd1);
    obs_valid = 0;
    finish_req(1'b0);
    check("player_valid_cnt", 32'(obs_valid), 32'd64);

    // Enemy3 at the bottom-right corner: clipped to 4x2.
    bus.enemyX[2] = 8'd156; bus.enemyY[2] = 7'd118; bus.enemyAlive = 4'b1111;
    start_req(4'd4, 1'b0);
    begin
      int nv;
      nv = 0;
      foreach (exp_q[i]) if (exp_q[i].v) nv++;
      check("enemy3_model_valid", 32'(nv), 32'd8);
    end
    check("enemy3_len", 32'(exp_q.size()), 32'd65);
    obs_valid = 0;
    finish_req(1'b0);
    check("enemy3_valid_cnt", 32'(obs_valid), 32'd8);

    // Dead enemy2: done pulse only.
    bus.enemyAlive = 4'b1101;
    start_req(4'd3, 1'b0);
    check("dead_len", 32'(exp_q.size()), 32'd1);
    check("dead_done", 32'(exp_q[0].dd), 32'd1);
    obs_valid = 0;
    finish_req(1'b0);
    check("dead_valid_cnt", 32'(obs_valid), 32'd0);

    // Ignored code.
    start_req(4'd9, 1'b0);
    check("code9_len", 32'(exp_q.size()), 32'd0);
    finish_req(1'b0);

    // Erase beats a bullet request.
    bus.bulletActive = 1'b1; bus.bulletX = 8'd40; bus.bulletY = 7'd40;
    start_req(4'd6, 1'b1);
    check("erase_len", 32'(exp_q.size()), 32'd19201);
    check("erase_last", 32'({exp_q[19199].x, exp_q[19199].y}), 32'({8'd159, 7'd119}));
`ifdef ERASE_STARFIELD_EN
    check("erase_star", 32'(exp_q[8 * 160 + 8].c), 32'd7);
`else
    check("erase_star", 32'(exp_q[8 * 160 + 8].c), 32'd0);
`endif
    check("erase_done", 32'(exp_q[19200].de), 32'd1);
    obs_valid = 0;
    finish_req(1'b0);
    check("erase_valid_cnt", 32'(obs_valid), 32'd19200);

    // Reset at erase pixel 500.
    start_req(4'd0, 1'b1);
    repeat (500) @(negedge clk);
    #1;
    chk_en = 1'b0;
    resetn = 1'b0;
    #1;
    check("reset_mid_erase", 32'(dut_out()), 32'd0);
    exp_q.delete();
    last_x = '0; last_y = '0; last_c = '0;
    bus.inEraseState = 1'b0;
    @(negedge clk); #1;
    resetn = 1'b1;
    chk_en = 1'b1;
    repeat (20) @(negedge clk);

    // Engine is back in IDLE: a bullet draw is accepted straight away.
    bus.bulletX = 8'd159; bus.bulletY = 7'd117; bus.bulletActive = 1'b1;
    start_req(4'd6, 1'b0);
    finish_req(1'b1);

    // Randomized requests with random positions and mid-scan changes.
    for (int n = 0; n < 40; n++) begin
      logic [3:0] code;
      bit erase;
      @(negedge clk); #1;
      scramble_objects();
      code  = 4'($urandom_range(0, 15));
      erase = ($urandom_range(0, 39) == 0);
      start_req(code, erase);
      finish_req(1'($urandom));
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
